mem_access_initiator: RTL and testbench



---
 rtl/mem_access_initiator.sv | 157 +++++++++++++++
 tb/tb_mem_access_initiator.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_initiator.sv
// mem_access_initiator: CPU-side initiator for the MainMem request/wait protocol.
// Arbitrates data (higher priority) against instruction fetch, issues one
// single-cycle req_mem_access pulse per access, holds address/data/type stable
// until the access completes, and returns read data with a one-cycle ack.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to compile in a WAIT-state
// watchdog that aborts an access after TIMEOUT_CYCLES busy cycles.
module mem_access_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,

  // Instruction-fetch requester (read only)
  input  logic        in_ifetch_req,
  input  logic [31:0] in_ifetch_addr,
  output logic        out_ifetch_ack,
  output logic [31:0] out_ifetch_data,

  // Data load/store requester
  input  logic        in_data_req,
  input  logic        in_data_we,
  input  logic [31:0] in_data_addr,
  input  logic [31:0] in_data_wdata,
  output logic        out_data_ack,
  output logic [31:0] out_data_rdata,

  output logic        out_busy,

  // Memory side
  output logic        out_mem_req_mem_access,
  output logic        out_mem_access_type,
  output logic [31:0] out_mem_addr,
  output logic [31:0] out_mem_data,
  input  logic        in_mem_wait_for_mem,
  input  logic [31:0] in_mem_data,

  output logic        out_timeout_err
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  state_e state_q;

  // 1 when the data path owns the current access, 0 for instruction fetch
  logic sel_data_q;

  // Memory must be idle before a new access may start
  logic accept;
  assign accept = !in_mem_wait_for_mem && (in_data_req || in_ifetch_req);

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] wd_cnt_q;
  logic       wd_expire;

  // Fires on the WAIT edge that would be the TIMEOUT_CYCLES-th busy sample
  assign wd_expire = in_mem_wait_for_mem && (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign out_timeout_err = 1'b0;
`endif

  // Access FSM with all outputs registered; pulses default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                <= StIdle;
      sel_data_q             <= 1'b0;
      out_ifetch_ack         <= 1'b0;
      out_ifetch_data        <= '0;
      out_data_ack           <= 1'b0;
      out_data_rdata         <= '0;
      out_busy               <= 1'b0;
      out_mem_req_mem_access <= 1'b0;
      out_mem_access_type    <= 1'b0;
      out_mem_addr           <= '0;
      out_mem_data           <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      wd_cnt_q               <= '0;
      out_timeout_err        <= 1'b0;
`endif
    end else begin
      out_mem_req_mem_access <= 1'b0;
      out_ifetch_ack         <= 1'b0;
      out_data_ack           <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      out_timeout_err        <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // Data wins; a losing fetch stays pending on its held request
            sel_data_q             <= in_data_req;
            out_mem_access_type    <= in_data_req & in_data_we;
            out_mem_addr           <= in_data_req ? in_data_addr : in_ifetch_addr;
            out_mem_data           <= in_data_req ? in_data_wdata : 32'h0;
            out_mem_req_mem_access <= 1'b1;
            out_busy               <= 1'b1;
            state_q                <= StReq;
          end
        end

        StReq: begin
`ifdef MEM_ACCESS_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
          state_q <= StWait;
        end

        StWait: begin
          if (!in_mem_wait_for_mem) begin
            // Writes leave the requester's data output untouched
            if (!out_mem_access_type) begin
              if (sel_data_q) begin
                out_data_rdata <= in_mem_data;
              end else begin
                out_ifetch_data <= in_mem_data;
              end
            end
            out_data_ack   <= sel_data_q;
            out_ifetch_ack <= !sel_data_q;
            state_q        <= StDone;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (wd_expire) begin
            if (sel_data_q) begin
              out_data_rdata <= '0;
            end else begin
              out_ifetch_data <= '0;
            end
            out_data_ack    <= sel_data_q;
            out_ifetch_ack  <= !sel_data_q;
            out_timeout_err <= 1'b1;
            state_q         <= StDone;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
`endif
        end

        StDone: begin
          out_busy <= 1'b0;
          state_q  <= StIdle;
        end

        default: begin
          out_busy <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_initiator.sv
// Self-checking bench for mem_access_initiator: a transaction-timestamp model
// predicts every output each cycle; directed tests pin key latencies/values.
module tb_mem_access_initiator;

  localparam int unsigned TimeoutCycles = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_ifetch_req = 1'b0;
  logic [31:0] in_ifetch_addr = '0;
  logic        in_data_req = 1'b0;
  logic        in_data_we = 1'b0;
  logic [31:0] in_data_addr = '0;
  logic [31:0] in_data_wdata = '0;
  logic        in_mem_wait_for_mem;
  logic [31:0] in_mem_data;
  logic        out_ifetch_ack, out_data_ack, out_busy;
  logic        out_mem_req_mem_access, out_mem_access_type, out_timeout_err;
  logic [31:0] out_ifetch_data, out_data_rdata, out_mem_addr, out_mem_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_initiator #(.TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .in_ifetch_req          (in_ifetch_req),
    .in_ifetch_addr         (in_ifetch_addr),
    .out_ifetch_ack         (out_ifetch_ack),
    .out_ifetch_data        (out_ifetch_data),
    .in_data_req            (in_data_req),
    .in_data_we             (in_data_we),
    .in_data_addr           (in_data_addr),
    .in_data_wdata          (in_data_wdata),
    .out_data_ack           (out_data_ack),
    .out_data_rdata         (out_data_rdata),
    .out_busy               (out_busy),
    .out_mem_req_mem_access (out_mem_req_mem_access),
    .out_mem_access_type    (out_mem_access_type),
    .out_mem_addr           (out_mem_addr),
    .out_mem_data           (out_mem_data),
    .in_mem_wait_for_mem    (in_mem_wait_for_mem),
    .in_mem_data            (in_mem_data),
    .out_timeout_err        (out_timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- memory
  // Big-endian byte memory; wait rises on the req edge and falls after `lat`
  // further edges. `stuck` keeps wait high forever, `flush` aborts it.
  logic [7:0]  mem [256];
  logic        mem_loaded = 1'b0;
  logic        mem_wait = 1'b0;
  logic        ext_wait = 1'b0;
  logic [31:0] mem_rdata = '0;
  bit          mbusy = 1'b0;
  int          mcnt = 0;
  logic [31:0] maddr = '0, mwdata = '0;
  logic        mwe = 1'b0;
  int          lat = 4;
  bit          lat_rand = 1'b0;
  bit          stuck = 1'b0;
  bit          flush = 1'b0;

  assign in_mem_wait_for_mem = mem_wait | ext_wait;
  assign in_mem_data = mem_rdata;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    rd_word = {mem[a[7:0]], mem[a[7:0] + 8'd1], mem[a[7:0] + 8'd2], mem[a[7:0] + 8'd3]};
  endfunction

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k) ^ 8'h5A;
      mem[16] <= 8'hDE;
      mem[17] <= 8'hAD;
      mem[18] <= 8'hBE;
      mem[19] <= 8'hEF;
      mem_loaded <= 1'b1;
    end
    if (flush) begin
      mbusy    <= 1'b0;
      mem_wait <= 1'b0;
    end else if (!mbusy) begin
      if (out_mem_req_mem_access) begin
        mbusy     <= 1'b1;
        mem_wait  <= 1'b1;
        mcnt      <= lat_rand ? int'($urandom_range(1, 6)) : lat;
        maddr     <= out_mem_addr;
        mwdata    <= out_mem_data;
        mwe       <= out_mem_access_type;
        mem_rdata <= $urandom;
      end
    end else if (!stuck) begin
      if (mcnt <= 1) begin
        mbusy    <= 1'b0;
        mem_wait <= 1'b0;
        if (mwe) begin
          for (int k = 0; k < 4; k++) mem[maddr[7:0] + 8'(k)] <= mwdata[31 - 8 * k -: 8];
        end else begin
          mem_rdata <= rd_word(maddr);
        end
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // ----------------------------------------------------------------- model
  // Each access is a timeline: accepted at edge acc, req pulse in the next
  // cycle, completes at the first edge >= acc+2 that sees wait low, ack for
  // one cycle after that, then one idle-return edge before a new acceptance.
  int          cyc = 0;
  bit          m_active = 1'b0, m_done = 1'b0, m_sel_data = 1'b0;
  int          m_acc = 0;
  logic        e_req = 1'b0, e_busy = 1'b0, e_type = 1'b0;
  logic        e_fack = 1'b0, e_dack = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_fdata = '0, e_ddata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      e_req    <= 1'b0;
      e_busy   <= 1'b0;
      e_type   <= 1'b0;
      e_fack   <= 1'b0;
      e_dack   <= 1'b0;
      e_err    <= 1'b0;
      e_addr   <= '0;
      e_wdata  <= '0;
      e_fdata  <= '0;
      e_ddata  <= '0;
    end else begin
      e_req  <= 1'b0;
      e_fack <= 1'b0;
      e_dack <= 1'b0;
      e_err  <= 1'b0;
      if (!m_active) begin
        if (!in_mem_wait_for_mem && (in_data_req || in_ifetch_req)) begin
          m_active   <= 1'b1;
          m_done     <= 1'b0;
          m_acc      <= cyc;
          m_sel_data <= in_data_req;
          e_addr     <= in_data_req ? in_data_addr : in_ifetch_addr;
          e_wdata    <= in_data_req ? in_data_wdata : 32'h0;
          e_type     <= in_data_req && in_data_we;
          e_req      <= 1'b1;
          e_busy     <= 1'b1;
        end
      end else if (!m_done) begin
        if (cyc >= m_acc + 2) begin
          if (!in_mem_wait_for_mem) begin
            m_done <= 1'b1;
            if (m_sel_data) e_dack <= 1'b1;
            else e_fack <= 1'b1;
            if (!e_type && m_sel_data) e_ddata <= in_mem_data;
            if (!e_type && !m_sel_data) e_fdata <= in_mem_data;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (cyc - m_acc - 1 == int'(TimeoutCycles)) begin
            m_done <= 1'b1;
            e_err  <= 1'b1;
            if (m_sel_data) begin
              e_dack  <= 1'b1;
              e_ddata <= '0;
            end else begin
              e_fack  <= 1'b1;
              e_fdata <= '0;
            end
          end
`endif
        end
      end else begin
        m_active <= 1'b0;
        e_busy   <= 1'b0;
      end
    end
  end

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    check("req_pulse", 32'(out_mem_req_mem_access), 32'(e_req));
    check("busy", 32'(out_busy), 32'(e_busy));
    check("access_type", 32'(out_mem_access_type), 32'(e_type));
    check("mem_addr", out_mem_addr, e_addr);
    check("mem_data", out_mem_data, e_wdata);
    check("ifetch_ack", 32'(out_ifetch_ack), 32'(e_fack));
    check("ifetch_data", out_ifetch_data, e_fdata);
    check("data_ack", 32'(out_data_ack), 32'(e_dack));
    check("data_rdata", out_data_rdata, e_ddata);
    check("timeout_err", 32'(out_timeout_err), 32'(e_err));
  end

  // --------------------------------------------------------------- helpers
  // Issue one access from an idle initiator; ack_at counts cycles after the
  // acceptance edge (-1 if no ack within the bound).
  task automatic run_access(input bit is_data, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int ack_at, output int pulses,
                            output logic pulse_type, output logic [31:0] rdata);
    @(posedge clk);
    #2;
    if (is_data) begin
      in_data_req   = 1'b1;
      in_data_we    = we;
      in_data_addr  = addr;
      in_data_wdata = wdata;
    end else begin
      in_ifetch_req  = 1'b1;
      in_ifetch_addr = addr;
    end
    @(posedge clk);
    ack_at     = -1;
    pulses     = 0;
    pulse_type = 1'b0;
    rdata      = '0;
    for (int i = 1; i <= 60 && ack_at < 0; i++) begin
      @(negedge clk);
      if (out_mem_req_mem_access) begin
        pulses++;
        pulse_type = out_mem_access_type;
      end
      if (is_data ? out_data_ack : out_ifetch_ack) begin
        ack_at = i;
        rdata  = is_data ? out_data_rdata : out_ifetch_data;
      end
    end
    @(posedge clk);
    #2;
    if (is_data) in_data_req = 1'b0;
    else in_ifetch_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench exceeded its time limit");
    $fatal(1, "time limit");
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    int          ack_at, pulses, dat, fat, unstable, acks;
    logic        ptype, dseen, fseen;
    logic [31:0] rd, cur;
    logic [31:0] pulse_addr [$];

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(out_busy), 32'h0);
    check("reset_req", 32'(out_mem_req_mem_access), 32'h0);
    check("reset_ifetch_data", out_ifetch_data, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fetch read: ack 7 cycles after acceptance with big-endian word
    run_access(1'b0, 1'b0, 32'h10, 32'h0, ack_at, pulses, ptype, rd);
    check("fetch_ack_cycle", 32'(ack_at), 32'd7);
    check("fetch_pulses", 32'(pulses), 32'd1);
    check("fetch_type", 32'(ptype), 32'h0);
    check("fetch_data", rd, 32'hDEADBEEF);

    // Data read, write, read back
    run_access(1'b1, 1'b0, 32'h10, 32'h0, ack_at, pulses, ptype, rd);
    check("dread_data", rd, 32'hDEADBEEF);
    run_access(1'b1, 1'b1, 32'h20, 32'h12345678, ack_at, pulses, ptype, rd);
    check("write_ack_cycle", 32'(ack_at), 32'd7);
    check("write_type", 32'(ptype), 32'h1);
    check("write_keeps_rdata", rd, 32'hDEADBEEF);
    run_access(1'b1, 1'b0, 32'h20, 32'h0, ack_at, pulses, ptype, rd);
    check("readback_data", rd, 32'h12345678);

    // Arbitration: both requests rise together
    @(posedge clk);
    #2;
    in_data_req    = 1'b1;
    in_data_we     = 1'b0;
    in_data_addr   = 32'h44;
    in_ifetch_req  = 1'b1;
    in_ifetch_addr = 32'h80;
    dseen = 1'b0;
    fseen = 1'b0;
    dat = -1;
    fat = -1;
    unstable = 0;
    cur = '0;
    for (int i = 0; i < 80 && !(dseen && fseen); i++) begin
      @(negedge clk);
      if (out_mem_req_mem_access) begin
        pulse_addr.push_back(out_mem_addr);
        cur = out_mem_addr;
      end else if (out_busy && out_mem_addr !== cur) begin
        unstable++;
      end
      if (out_data_ack) begin
        dseen = 1'b1;
        dat = i;
      end
      if (out_ifetch_ack) begin
        fseen = 1'b1;
        fat = i;
      end
      @(posedge clk);
      #2;
      if (dseen) in_data_req = 1'b0;
      if (fseen) in_ifetch_req = 1'b0;
    end
    check("arb_pulse_count", 32'(pulse_addr.size()), 32'd2);
    if (pulse_addr.size() == 2) begin
      check("arb_first_addr", pulse_addr[0], 32'h44);
      check("arb_second_addr", pulse_addr[1], 32'h80);
    end
    check("arb_data_first", 32'(dseen && fseen && (fat - dat >= 4)), 32'h1);
    check("arb_addr_stable", 32'(unstable), 32'd0);

    // Reset during WAIT, released while memory still busy
    lat = 10;
    @(posedge clk);
    #2;
    in_data_req  = 1'b1;
    in_data_we   = 1'b0;
    in_data_addr = 32'h10;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(out_busy), 32'h0);
    check("midreset_addr", out_mem_addr, 32'h0);
    check("midreset_rdata", out_data_rdata, 32'h0);
    check("midreset_fdata", out_ifetch_data, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    pulses = 0;
    acks = 0;
    for (int i = 0; i < 40 && in_mem_wait_for_mem; i++) begin
      @(negedge clk);
      if (out_mem_req_mem_access) pulses++;
      if (out_data_ack) acks++;
    end
    check("stale_no_req", 32'(pulses), 32'd0);
    check("stale_no_ack", 32'(acks), 32'd0);
    lat = 4;
    ack_at = -1;
    for (int i = 0; i < 40 && ack_at < 0; i++) begin
      @(negedge clk);
      if (out_data_ack) ack_at = i;
    end
    check("after_reset_ack", 32'(ack_at >= 0), 32'h1);
    check("after_reset_data", out_data_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #2;
    in_data_req = 1'b0;
    repeat (2) @(posedge clk);

    // Watchdog: memory never releases wait
    stuck = 1'b1;
    @(posedge clk);
    #2;
    in_ifetch_req  = 1'b1;
    in_ifetch_addr = 32'h30;
    @(posedge clk);
    ack_at = -1;
    ptype  = 1'b0;
    rd     = 32'hFFFFFFFF;
    for (int i = 1; i <= 40 && ack_at < 0; i++) begin
      @(negedge clk);
      if (out_ifetch_ack) begin
        ack_at = i;
        ptype  = out_timeout_err;
        rd     = out_ifetch_data;
      end
    end
`ifdef MEM_ACCESS_TIMEOUT_EN
    check("wd_ack_cycle", 32'(ack_at), 32'd10);
    check("wd_err", 32'(ptype), 32'h1);
    check("wd_data", rd, 32'h0);
`else
    check("wd_no_ack", 32'(ack_at), 32'hFFFFFFFF);
    check("wd_still_busy", 32'(out_busy), 32'h1);
`endif
    @(posedge clk);
    #2;
    in_ifetch_req = 1'b0;
    rst_n = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #2;
    flush = 1'b0;
    stuck = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Randomized traffic with variable latency and spurious memory-busy
    lat_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      ext_wait = ($urandom_range(0, 7) == 0);
      if (out_data_ack) begin
        in_data_req = 1'b0;
      end else if (!in_data_req && $urandom_range(0, 2) == 0) begin
        in_data_req   = 1'b1;
        in_data_we    = 1'($urandom_range(0, 1));
        in_data_addr  = $urandom;
        in_data_wdata = $urandom;
      end
      if (out_ifetch_ack) begin
        in_ifetch_req = 1'b0;
      end else if (!in_ifetch_req && $urandom_range(0, 2) == 0) begin
        in_ifetch_req  = 1'b1;
        in_ifetch_addr = $urandom;
      end
    end
    ext_wait = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
